restoring_div_ctrl: RTL and testbench

//  Sequencer for unsigned restoring division on the shared WIDTH-bit adder/subtractor
//  (A, B, Op in; S, C out; Op=1 subtracts; on subtract C=1 means borrow, i.e. A<B).

---
 rtl/restoring_div_ctrl_pkg.sv | 13 +
 rtl/restoring_div_ctrl.sv | 146 ++++++++++++++
 tb/tb_restoring_div_ctrl.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/restoring_div_ctrl_pkg.sv
// Shared definitions for the restoring-division sequencer: state encoding and default width.
package restoring_div_ctrl_pkg;

  localparam int DIV_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    SUB   = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/restoring_div_ctrl.sv
// Unsigned restoring-division sequencer driving an external shared add/sub unit.
// Handshake: start is sampled only in IDLE; done pulses one cycle when quotient/remainder are valid.
module restoring_div_ctrl
  import restoring_div_ctrl_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero,
  output logic [WIDTH-1:0] as_a,
  output logic [WIDTH-1:0] as_b,
  output logic             as_op,
  input  logic [WIDTH-1:0] as_s,
  input  logic             as_c,
  output state_e           dbg_state
);

  localparam int CW = $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] r_q, r_d, q_q, q_d, d_q, d_d;
  logic [WIDTH-1:0] quo_q, quo_d, rem_q, rem_d;
  logic             msb_q, msb_d;
  logic             busy_q, busy_d, done_q, done_d, dz_q, dz_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             accept;
  logic [WIDTH-1:0] r_upd, q_upd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      msb_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      msb_q   <= msb_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
      cnt_q   <= cnt_d;
    end
  end

  // The add/sub bus is only driven in SUB so the shared unit sees no stray requests.
  always_comb begin
    as_a  = '0;
    as_b  = '0;
    as_op = 1'b0;
    if (state_q == SUB) begin
      as_a  = r_q;
      as_b  = d_q;
      as_op = 1'b1;
    end
  end

  // A set msb means the shifted remainder exceeds 2^WIDTH > D, so the subtraction must be kept.
  assign accept = msb_q | ~as_c;
  assign r_upd  = accept ? as_s : r_q;
  assign q_upd  = {q_q[WIDTH-1:1], accept};

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    msb_d   = msb_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dz_d    = dz_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (divisor != '0) begin
            d_d     = divisor;
            q_d     = dividend;
            r_d     = '0;
            msb_d   = 1'b0;
            cnt_d   = '0;
            dz_d    = 1'b0;
            busy_d  = 1'b1;
            state_d = SHIFT;
          end else begin
            quo_d   = '1;
            rem_d   = dividend;
            dz_d    = 1'b1;
            done_d  = 1'b1;
            state_d = DONE;
          end
        end
      end
      SHIFT: begin
        {msb_d, r_d, q_d} = {r_q, q_q, 1'b0};
        state_d = SUB;
      end
      SUB: begin
        r_d   = r_upd;
        q_d   = q_upd;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          quo_d   = q_upd;
          rem_d   = r_upd;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          state_d = SHIFT;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign div_zero  = dz_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_restoring_div_ctrl.sv
// Bench for restoring_div_ctrl with an inline 4-bit add/sub model and a queue-based scoreboard.
module tb_restoring_div_ctrl;
  import restoring_div_ctrl_pkg::*;

  localparam int W = 4;

  logic         clk, rst, start;
  logic [W-1:0] dividend, divisor;
  logic         busy, done, div_zero;
  logic [W-1:0] quotient, remainder;
  logic [W-1:0] as_a, as_b, as_s;
  logic         as_op, as_c;
  state_e       dbg_state;

  int compared = 0;
  int mismatched = 0;
  logic [2*W:0] exp_q[$];

  restoring_div_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_zero(div_zero), .as_a(as_a), .as_b(as_b), .as_op(as_op),
    .as_s(as_s), .as_c(as_c), .dbg_state(dbg_state)
  );

  // Shared add/sub unit: on subtract, C is the borrow (A < B).
  logic [W:0] as_full;
  assign as_full = as_op ? ({1'b0, as_a} - {1'b0, as_b}) : ({1'b0, as_a} + {1'b0, as_b});
  assign as_s    = as_full[W-1:0];
  assign as_c    = as_full[W];

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (done) begin
        if (exp_q.size() == 0) begin
          check("done_unexpected", 32'd1, 32'd0);
        end else begin
          logic [2*W:0] e;
          e = exp_q.pop_front();
          check("result{dz,q,r}", {23'd0, div_zero, quotient, remainder}, {23'd0, e});
        end
      end
      if (dbg_state != SUB)
        check("bus_quiet", {23'd0, as_op, as_a, as_b}, 32'd0);
    end
  end

  task automatic wait_done(input int exp_lat, input logic chk_busy);
    int lat;
    lat = 1;
    if (chk_busy) check("busy_after_accept", {31'd0, busy}, 32'd1);
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("latency", lat, exp_lat);
    check("busy_at_done", {31'd0, busy}, 32'd0);
  endtask

  task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    exp_q.push_back({edz, eq, er});
    @(negedge clk);
    start = 1'b0;
    wait_done((b == 0) ? 1 : 2 * W + 1, b != 0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    dividend = '0;
    divisor = '0;
    repeat (2) @(negedge clk);
    check("reset_outputs", {22'd0, busy, done, div_zero, quotient, remainder}, 32'd0);
    check("reset_state", {30'd0, dbg_state}, {30'd0, IDLE});
    rst = 1'b0;

    // directed vectors
    do_div(4'd13, 4'd3, 4'd4, 4'd1, 1'b0);
    do_div(4'd15, 4'd1, 4'd15, 4'd0, 1'b0);
    do_div(4'd15, 4'd15, 4'd1, 4'd0, 1'b0);
    do_div(4'd2, 4'd7, 4'd0, 4'd2, 1'b0);
    do_div(4'd8, 4'd9, 4'd0, 4'd8, 1'b0);
    do_div(4'd9, 4'd0, 4'hF, 4'd9, 1'b1);

    // start held while busy: 13/3 completes, 6/2 accepted only after done
    @(negedge clk);
    dividend = 4'd13;
    divisor  = 4'd3;
    start    = 1'b1;
    exp_q.push_back({1'b0, 4'd4, 4'd1});
    @(negedge clk);
    dividend = 4'd6;
    divisor  = 4'd2;
    wait_done(2 * W + 1, 1'b1);
    exp_q.push_back({1'b0, 4'd3, 4'd0});
    @(negedge clk);
    check("idle_after_done", {30'd0, dbg_state}, {30'd0, IDLE});
    @(negedge clk);
    start = 1'b0;
    wait_done(2 * W + 1, 1'b1);

    // asynchronous reset in the middle of 14/5
    @(negedge clk);
    dividend = 4'd14;
    divisor  = 4'd5;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("midop_reset_outputs", {22'd0, busy, done, div_zero, quotient, remainder}, 32'd0);
    check("midop_reset_state", {30'd0, dbg_state}, {30'd0, IDLE});
    @(negedge clk);
    rst = 1'b0;
    do_div(4'd14, 4'd5, 4'd2, 4'd4, 1'b0);

    // exhaustive sweep against a reference model
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        logic [W-1:0] mq, mr;
        if (b == 0) begin
          mq = 4'hF;
          mr = W'(a);
        end else begin
          mq = W'(a / b);
          mr = W'(a % b);
        end
        do_div(W'(a), W'(b), mq, mr, b == 0);
      end
    end

    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
